// File: rtl/div_edge_bcd_counter.sv
// Turns each rising edge of the divided clock into a single clk_in tick, counts ticks
// in four BCD digits (0000-9999, wrapping) and scans them onto an active-low 7-segment display.
module div_edge_bcd_counter #(
    parameter int SCAN_LEN = 16
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        div_clk,
    input  logic        pause,
    input  logic        clear,
    output logic        tick,
    output logic [15:0] count,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int              REF_W  = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(SCAN_LEN - 1);

    logic              sync1_r;
    logic              sync2_r;
    logic              sync3_r;
    logic              rise_s;
    logic              accept_s;
    logic [16:0]       inc_s;
    logic [REF_W-1:0]  refresh_r;
    logic [1:0]        digit_r;
    logic [3:0]        digit_val_s;

    // BCD increment with ripple carry; bit 16 is the carry out of the thousands digit.
    // A digit at or above 9 rolls to 0, so a digit can never leave the 0-9 range.
    function automatic logic [16:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        carry  = 1'b1;
        result = 16'd0;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] >= 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[i*4 +: 4] = value[i*4 +: 4];
                carry            = 1'b0;
            end
        end
        return {carry, result};
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; anything outside 0-9 blanks the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Three-flop synchronizer; resets high so a div_clk already high at release is not an edge.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
        end else begin
            sync1_r <= div_clk;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Edge detection and acceptance decode.
    always_comb begin
        rise_s   = sync2_r & ~sync3_r;
        accept_s = rise_s & ~pause;
        inc_s    = bcd_inc(count);
    end

    // Tick, count and wrap registers; clear wins over everything, a paused edge is lost.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tick  <= 1'b0;
            count <= 16'd0;
            wrap  <= 1'b0;
        end else if (clear) begin
            tick  <= 1'b0;
            count <= 16'd0;
            wrap  <= 1'b0;
        end else if (accept_s) begin
            tick  <= 1'b1;
            count <= inc_s[15:0];
            wrap  <= inc_s[16];
        end else begin
            tick  <= 1'b0;
            count <= count;
            wrap  <= 1'b0;
        end
    end

    // Display scan: each digit is held for SCAN_LEN cycles, then the next digit is selected.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            refresh_r <= '0;
            digit_r   <= 2'd0;
        end else if (refresh_r == REF_LAST) begin
            refresh_r <= '0;
            digit_r   <= digit_r + 2'd1;
        end else begin
            refresh_r <= refresh_r + REF_W'(1);
            digit_r   <= digit_r;
        end
    end

    // Digit select and segment decode follow the count register with no extra delay.
    always_comb begin
        an = ~(4'b0001 << digit_r);
        case (digit_r)
            2'd0:    digit_val_s = count[3:0];
            2'd1:    digit_val_s = count[7:4];
            2'd2:    digit_val_s = count[11:8];
            2'd3:    digit_val_s = count[15:12];
            default: digit_val_s = 4'd0;
        endcase
        seg = seg_decode(digit_val_s);
    end

endmodule

// File: doc/div_edge_bcd_counter.md
# div_edge_bcd_counter

Consumes the divide-by-32 clock produced by the clock-divider stage and turns each of its rising edges into a single-cycle tick in the `clk_in` domain. Ticks drive a 4-digit BCD event counter (0000–9999, with wrap) that is shown on a multiplexed active-low 4-digit 7-segment display. The block sits directly downstream of the divider and is the first stage that makes the divided clock visible on the board.

## Interface
- `SCAN_LEN`, default 16: number of `clk_in` cycles each digit stays selected; must be ≥ 2.
- `clk_in` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset; one clock, asynchronous active-low reset.
- `div_clk` in 1: divided clock from the divider (e.g. `clk_div_thirty_two`); treated as an asynchronous level.
- `pause` in 1: while high, detected edges are discarded.
- `clear` in 1: synchronous clear of the count; has priority over `pause` and ticks.
- `tick` out 1: one-cycle pulse for each accepted `div_clk` rising edge.
- `count` out 16: BCD count; `[15:12]` thousands, `[11:8]` hundreds, `[7:4]` tens, `[3:0]` units.
- `wrap` out 1: one-cycle pulse on the 9999→0000 transition.
- `an` out 4: digit select, active-low; `an[0]` = units.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
- Synchronizer: three flops `s1→s2→s3` sample `div_clk`. Raw edge `rise = s2 & ~s3`.
- Acceptance:
  - `tick` is registered, `tick <= rise & ~pause & ~clear`.
  - An edge seen while `pause=1` is dropped, not deferred.
- Count, evaluated every cycle with this priority:
  1. `clear=1`: `count <= 0`, `wrap <= 0`.
  2. Accepted edge: BCD increment. A digit at 9 becomes 0 and carries into the next digit. 9999 becomes 0000 with `wrap <= 1`.
  3. Otherwise hold, `wrap <= 0`.
- No BCD digit ever holds a value above 9.
- Scan:
  - Refresh counter `r` runs 0..`SCAN_LEN-1`.
  - When `r` wraps, digit index `d` advances 0→1→2→3→0.
  - `an = ~(4'b0001 << d)`.
  - `seg` decodes `count` digit `d` combinationally. Patterns: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- Reset (`rst=0`, asynchronous):
  - `s1`, `s2`, `s3` = 1, so a `div_clk` already high at release causes no edge.
  - `tick` = 0, `wrap` = 0, `count` = 0.
  - `r` = 0, `d` = 0, giving `an` = 1110 and `seg` = 1000000.
- Reset mid-operation aborts any in-flight edge; no tick is generated for it.

## Timing
- Edge latency: when `div_clk` is first sampled high at `clk_in` edge N (into `s1`), `rise` is true after edge N+1. `tick`, `count` and `wrap` update together at edge N+2.
- `tick` and `wrap` are exactly one cycle wide. `wrap` coincides with the `tick` that produces 0000.
- `div_clk` high or low phases shorter than 2 `clk_in` cycles are not guaranteed to be detected. The divide-by-32 input (16-cycle phases) is always detected.
- `clear` and an accepted edge in the same cycle: the count goes to 0000, and `tick` and `wrap` stay 0.
- `pause` is sampled in the cycle where `rise` is true. Deasserting `pause` later does not recover that edge.
- Digit dwell time is exactly `SCAN_LEN` cycles. One full scan takes `4*SCAN_LEN` cycles.
- `seg` reflects a `count` change in the same cycle the `count` register updates. `an` changes in the cycle after `r` reaches `SCAN_LEN-1`.

## Test plan
- Reset and count: `clk_in` 10 ns, `div_clk` period 320 ns, release `rst` → `tick` every 32 cycles; `count` 0000→0001→0002; each `tick` is 1 cycle wide, 3 edges after `div_clk` rises.
- Reset with `div_clk` already high at release → no `tick` until the next low→high transition of `div_clk`.
- Carry and wrap: bring `count` to 0009 → the next tick gives 0010. Bring it to 0099 → 0100. Bring it to 9999 → 0000 with a 1-cycle `wrap` aligned to `tick`.
- Pause and clear:
  - `pause=1` across 3 edges → `count` unchanged, no `tick`.
  - `clear=1` in the same cycle `rise` is true, with `count`=0042 → `count`=0000, no `tick`, no `wrap`.
- Scan with `SCAN_LEN`=4 and `count`=1234:
  - `an` cycles 1110, 1101, 1011, 0111, 4 cycles each.
  - `seg` is 0011001, 0110000, 0100100, 1111001 respectively.
- Asynchronous reset asserted mid-count (`count`=0057) → all outputs return to reset values without waiting for a `clk_in` edge.
